// File: rtl/bioz_adc_pkg.sv
// Shared constants and state type for the BioZ/EMG AFE SAR ADC controller.
// Holds default resolution/averaging, the frame length and the FSM state enum.
package bioz_adc_pkg;

    localparam int unsigned NBITS_DEF    = 12;
    localparam int unsigned AVG_LOG2_DEF = 0;
    localparam int unsigned ADC_FRAME    = 15;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT
    } state_e;

endpackage

// File: rtl/bioz_sar_register.sv
// SAR bit pointer and trial/keep register driving the capacitive DAC code.
// Ports: clk/rst_n, clear/load/step controls, comp in; dac_code, last_bit, final_code out.
module bioz_sar_register #(
    parameter int NBITS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             comp,
    output logic [NBITS-1:0] dac_code,
    output logic             last_bit,
    output logic [NBITS-1:0] final_code
);

    localparam logic [NBITS-1:0] TOP = {1'b1, {(NBITS-1){1'b0}}};

    logic [NBITS-1:0] code_q, code_d;
    logic [NBITS-1:0] mask_q, mask_d;
    logic [NBITS-1:0] kept;

    // mask_q is one-hot on the bit under trial
    always_comb begin
        kept   = comp ? code_q : (code_q & ~mask_q);
        code_d = code_q;
        mask_d = mask_q;
        if (clear) begin
            code_d = '0;
            mask_d = '0;
        end else if (load) begin
            code_d = TOP;
            mask_d = TOP;
        end else if (step) begin
            code_d = kept | (mask_q >> 1);
            mask_d = mask_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            mask_q <= '0;
        end else begin
            code_q <= code_d;
            mask_q <= mask_d;
        end
    end

    assign dac_code   = code_q;
    assign last_bit   = mask_q[0];
    assign final_code = kept;

endmodule

// File: rtl/bioz_sar_adc_ctrl.sv
// SAR ADC controller: start-edge detect, sample/convert FSM, averaging, overrun.
// Ports: clk_ADC/Resetn, ADC_En, ADC_Start, Comp, Clr_Overrun in; Sample, Dac_Code, Busy, Result, Result_Valid, Overrun out.
module bioz_sar_adc_ctrl
    import bioz_adc_pkg::*;
#(
    parameter int NBITS    = NBITS_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic             clk_ADC,
    input  logic             Resetn,
    input  logic             ADC_En,
    input  logic             ADC_Start,
    input  logic             Comp,
    input  logic             Clr_Overrun,
    output logic             Sample,
    output logic [NBITS-1:0] Dac_Code,
    output logic             Busy,
    output logic [NBITS-1:0] Result,
    output logic             Result_Valid,
    output logic             Overrun
);

    localparam int AW = NBITS + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((2 ** AVG_LOG2) - 1);

    state_e           state_q, state_d;
    logic             start_q;
    logic             arm_q;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             start_evt;
    logic             busy;
    logic             sar_clear, sar_load, sar_step;
    logic             last_bit;
    logic [NBITS-1:0] final_code;
    logic [AW-1:0]    sum;

    // arm_q blocks a start held high across reset release until it
    // has been seen low at least once
    assign start_evt = ADC_Start & ~start_q & arm_q;
    assign busy      = (state_q != IDLE);
    assign sum       = acc_q + AW'(final_code);

    bioz_sar_register #(
        .NBITS(NBITS)
    ) u_sar (
        .clk       (clk_ADC),
        .rst_n     (Resetn),
        .clear     (sar_clear),
        .load      (sar_load),
        .step      (sar_step),
        .comp      (Comp),
        .dac_code  (Dac_Code),
        .last_bit  (last_bit),
        .final_code(final_code)
    );

    always_comb begin
        state_d   = state_q;
        sar_clear = 1'b0;
        sar_load  = 1'b0;
        sar_step  = 1'b0;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        ovr_d     = ovr_q;

        if (Clr_Overrun) ovr_d = 1'b0;
        if (start_evt && busy) ovr_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start_evt && ADC_En) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (!ADC_En) begin
                    state_d   = IDLE;
                    sar_clear = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    state_d  = CONVERT;
                    sar_load = 1'b1;
                end
            end
            CONVERT: begin
                if (!ADC_En) begin
                    state_d   = IDLE;
                    sar_clear = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else if (last_bit) begin
                    state_d   = IDLE;
                    sar_clear = 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        result_d = NBITS'(sum >> AVG_LOG2);
                        valid_d  = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    sar_step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ADC or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            arm_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= ADC_Start;
            arm_q    <= arm_q | ~ADC_Start;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign Sample       = (state_q == SAMPLE);
    assign Busy         = busy;
    assign Result       = result_q;
    assign Result_Valid = valid_q;
    assign Overrun      = ovr_q;

endmodule

// File: tb/tb_bioz_sar_adc_ctrl.sv
// Self-checking bench for bioz_sar_adc_ctrl (NBITS=12, AVG_LOG2 = 0 and 2).
// Vector table of frames plus sequences for overrun, abort and reset corners.
module tb_bioz_sar_adc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        start;
    logic        clr;
    logic [11:0] vin;

    logic        smp0, busy0, val0, ovr0, comp0;
    logic [11:0] dac0, res0;
    logic        smp1, busy1, val1, ovr1, comp1;
    logic [11:0] dac1, res1;

    int errors = 0;
    int checks = 0;
    bit avg_chk = 1'b0;
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [11:0] last_res;

    always #5 clk = ~clk;

    assign comp0 = (vin >= dac0);
    assign comp1 = (vin >= dac1);

    bioz_sar_adc_ctrl #(.NBITS(12), .AVG_LOG2(0)) dut0 (
        .clk_ADC(clk), .Resetn(rst_n), .ADC_En(en),
        .ADC_Start(start), .Comp(comp0), .Clr_Overrun(clr),
        .Sample(smp0), .Dac_Code(dac0), .Busy(busy0),
        .Result(res0), .Result_Valid(val0), .Overrun(ovr0)
    );

    bioz_sar_adc_ctrl #(.NBITS(12), .AVG_LOG2(2)) dut1 (
        .clk_ADC(clk), .Resetn(rst_n), .ADC_En(en),
        .ADC_Start(start), .Comp(comp1), .Clr_Overrun(clr),
        .Sample(smp1), .Dac_Code(dac1), .Busy(busy1),
        .Result(res1), .Result_Valid(val1), .Overrun(ovr1)
    );

    typedef struct {
        logic [11:0] vin;
        logic [11:0] exp0;
        bit          strobe1;
        logic [11:0] exp1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: strobes popped and compared as the DUTs produce them
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (val0) begin
                if (q0.size() == 0) chk("unexpected_valid0", 32'(res0), 32'hFFFF_FFFF);
                else chk("result0", 32'(res0), 32'(q0.pop_front()));
            end
            if (avg_chk && val1) begin
                if (q1.size() == 0) chk("unexpected_valid1", 32'(res1), 32'hFFFF_FFFF);
                else chk("result1", 32'(res1), 32'(q1.pop_front()));
            end
        end
    end

    // one 15-cycle frame; k counts edges after E0
    task automatic frame(input logic [11:0] v, input bit detail);
        logic [31:0] e;
        vin = v;
        q0.push_back(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (detail) begin
                if (k == 0) begin
                    chk("sample_e0", 32'(smp0), 1);
                    chk("busy_e0", 32'(busy0), 1);
                    chk("dac_e0", 32'(dac0), 0);
                end else if (k <= 12) begin
                    e = (32'(v) & ~((32'd1 << (13 - k)) - 1)) | (32'd1 << (12 - k));
                    chk($sformatf("dac_e%0d", k), 32'(dac0), e);
                    if (k == 1) chk("sample_e1", 32'(smp0), 0);
                    if (k == 12) chk("busy_e12", 32'(busy0), 1);
                end else begin
                    chk("valid_e13", 32'(val0), 1);
                    chk("busy_e13", 32'(busy0), 0);
                    chk("dac_e13", 32'(dac0), 0);
                end
            end
            @(posedge clk);
            #1;
        end
        last_res = v;
    endtask

    initial begin
        vecs[0] = '{12'd100,  12'd100,  1'b0, 12'd0};
        vecs[1] = '{12'd101,  12'd101,  1'b0, 12'd0};
        vecs[2] = '{12'd102,  12'd102,  1'b0, 12'd0};
        vecs[3] = '{12'd103,  12'd103,  1'b1, 12'd101};
        vecs[4] = '{12'hA5C,  12'hA5C,  1'b0, 12'd0};
        vecs[5] = '{12'h000,  12'h000,  1'b0, 12'd0};
        vecs[6] = '{12'hFFF,  12'hFFF,  1'b0, 12'd0};
        vecs[7] = '{12'h123,  12'h123,  1'b1, 12'h6DF};

        rst_n = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        clr   = 1'b0;
        vin   = '0;
        #12;
        chk("rst_sample", 32'(smp0), 0);
        chk("rst_dac", 32'(dac0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_result", 32'(res0), 0);
        chk("rst_valid", 32'(val0), 0);
        chk("rst_overrun", 32'(ovr0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        avg_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].strobe1) q1.push_back(vecs[i].exp1);
            frame(vecs[i].vin, 1'b1);
            chk($sformatf("vec%0d_result", i), 32'(res0), 32'(vecs[i].exp0));
        end
        chk("avg_pending", 32'(q1.size()), 0);
        avg_chk = 1'b0;

        // second start while busy, then set and clear at the same edge
        vin = 12'hA5C;
        q0.push_back(12'hA5C);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 5) start = 1'b1;
            if (k == 9) begin
                start = 1'b1;
                clr   = 1'b1;
            end
            tick();
            start = 1'b0;
            clr   = 1'b0;
            if (k == 5) chk("ovr_set", 32'(ovr0), 1);
            if (k == 5) chk("ovr_busy", 32'(busy0), 1);
            if (k == 9) chk("ovr_set_wins", 32'(ovr0), 1);
        end
        chk("ovr_sticky", 32'(ovr0), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovr_clear", 32'(ovr0), 0);

        // start arriving on the bit-0 edge
        q0.push_back(12'hA5C);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 13) start = 1'b1;
            tick();
        end
        chk("bit0_ovr", 32'(ovr0), 1);
        chk("bit0_busy", 32'(busy0), 0);
        tick();
        chk("bit0_ignored", 32'(busy0), 0);
        start = 1'b0;
        clr   = 1'b1;
        tick();
        clr = 1'b0;
        chk("bit0_clear", 32'(ovr0), 0);
        last_res = 12'hA5C;

        // start with converter disabled
        en    = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("dis_busy", 32'(busy0), 0);
        chk("dis_ovr", 32'(ovr0), 0);
        en = 1'b1;
        tick();

        // abort six edges after E0
        vin   = 12'h777;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        en = 1'b0;
        tick();
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_dac", 32'(dac0), 0);
        chk("abort_sample", 32'(smp0), 0);
        for (int k = 0; k < 10; k++) tick();
        chk("abort_hold", 32'(res0), 32'(last_res));
        en = 1'b1;
        tick();
        frame(12'h3C3, 1'b1);

        // asynchronous reset mid-conversion, start held across release
        vin   = 12'h5A5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy0), 0);
        chk("mid_rst_dac", 32'(dac0), 0);
        chk("mid_rst_result", 32'(res0), 0);
        chk("mid_rst_valid", 32'(val0), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("held_start", 32'(busy0), 0);
        end
        start = 1'b0;
        tick();
        frame(12'h5A5, 1'b1);

        for (int k = 0; k < 4; k++) tick();
        chk("pending0", 32'(q0.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
